// File: rtl/switch_debounce_toggle.sv
// switch_debounce_toggle: 4-channel switch synchronizer, debouncer and release-toggled LEDs.
// Define SWITCH_SYNC_EN to insert a two-flop synchronizer ahead of each debouncer.
module switch_debounce_toggle #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Switch_Clean,
  output logic [3:0] o_Release_Pulse,
  output logic [3:0] o_LED
);
  localparam int CW = DEBOUNCE_LIMIT > 1 ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] LIM1 = CW'(DEBOUNCE_LIMIT - 1);
  logic [3:0] sample;
  logic [3:0] clean_q, clean_d, pulse_q, led_q, rel;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
`ifdef SWITCH_SYNC_EN
  logic [3:0] s1_q, s2_q;
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_Switch;
      s2_q <= s1_q;
    end
  assign sample = s2_q;
`else
  assign sample = i_Switch;
`endif
  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic diff, hit;
    always_comb begin
      diff = sample[n] != clean_q[n];
      hit = diff && cnt_q[n] == LIM1;
      cnt_d[n] = (diff && !hit) ? cnt_q[n] + 1'b1 : '0;
      clean_d[n] = hit ? sample[n] : clean_q[n];
    end
    always_ff @(posedge i_Clk or posedge i_Reset)
      if (i_Reset) cnt_q[n] <= '0;
      else cnt_q[n] <= cnt_d[n];
  end
  assign rel = clean_q & ~clean_d;
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      clean_q <= '0;
      pulse_q <= '0;
      led_q <= '0;
    end else begin
      clean_q <= clean_d;
      pulse_q <= rel;
      led_q <= led_q ^ rel;
    end
  assign o_Switch_Clean = clean_q;
  assign o_Release_Pulse = pulse_q;
  assign o_LED = led_q;
endmodule

// File: tb/tb_switch_debounce_toggle.sv
// tb_switch_debounce_toggle: directed vector bench for switch_debounce_toggle with DEBOUNCE_LIMIT=4.
module tb_switch_debounce_toggle;
`ifdef SWITCH_SYNC_EN
  localparam int L = 6;
`else
  localparam int L = 4;
`endif
  typedef struct {
    string      nm;
    logic [3:0] sw;
    int         hold;
    logic [3:0] clean;
    logic [3:0] pulse;
    logic [3:0] led;
  } vec_t;
  logic clk = 0, rst = 0;
  logic [3:0] sw = 4'b1111;
  logic [3:0] clean, pulse, led;
  int checks = 0, errors = 0;
  vec_t v [12];
  switch_debounce_toggle #(.DEBOUNCE_LIMIT(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw),
    .o_Switch_Clean(clean), .o_Release_Pulse(pulse), .o_LED(led)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [3:0] c, input logic [3:0] p, input logic [3:0] l);
    checks++;
    if ({clean, pulse, led} !== {c, p, l}) begin
      errors++;
      $display("FAIL %s: clean/pulse/led got %b/%b/%b expected %b/%b/%b", nm, clean, pulse, led, c, p, l);
    end
  endtask
  initial begin
    v[0]  = '{"press0_early",   4'b0001, L-1, 4'b0000, 4'b0000, 4'b0000};
    v[1]  = '{"press0_edge",    4'b0001, 1,   4'b0001, 4'b0000, 4'b0000};
    v[2]  = '{"rel0_early",     4'b0000, L-1, 4'b0001, 4'b0000, 4'b0000};
    v[3]  = '{"rel0_edge",      4'b0000, 1,   4'b0000, 4'b0001, 4'b0001};
    v[4]  = '{"rel0_after",     4'b0000, 1,   4'b0000, 4'b0000, 4'b0001};
    v[5]  = '{"press0_again",   4'b0001, L,   4'b0001, 4'b0000, 4'b0001};
    v[6]  = '{"rel0_again",     4'b0000, L,   4'b0000, 4'b0001, 4'b0000};
    v[7]  = '{"rel0_again_aft", 4'b0000, 1,   4'b0000, 4'b0000, 4'b0000};
    v[8]  = '{"press_all",      4'b1111, L,   4'b1111, 4'b0000, 4'b0000};
    v[9]  = '{"rel_all_early",  4'b0000, L-1, 4'b1111, 4'b0000, 4'b0000};
    v[10] = '{"rel_all_edge",   4'b0000, 1,   4'b0000, 4'b1111, 4'b1111};
    v[11] = '{"rel_all_after",  4'b0000, 1,   4'b0000, 4'b0000, 4'b1111};
    #2 rst = 1;
    #1 chk("reset_async", 4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    chk("reset_held", 4'b0000, 4'b0000, 4'b0000);
    rst = 0;
    repeat (L-1) step();
    chk("held_early", 4'b0000, 4'b0000, 4'b0000);
    step();
    chk("held_rise", 4'b1111, 4'b0000, 4'b0000);
    rst = 1;
    sw = 4'b0000;
    #1 chk("reset_clear", 4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    rst = 0;
    repeat (L+2) step();
    chk("idle", 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      sw = v[i].sw;
      repeat (v[i].hold) step();
      chk(v[i].nm, v[i].clean, v[i].pulse, v[i].led);
    end
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int j = 0; j < 3; j++) begin
        step();
        chk("bounce", 4'b0000, 4'b0000, 4'b1111);
      end
    end
    sw = 4'b0000;
    repeat (L+2) step();
    chk("bounce_settled", 4'b0000, 4'b0000, 4'b1111);
    sw = 4'b0010;
    repeat (L-2) step();
    chk("midcount_pre", 4'b0000, 4'b0000, 4'b1111);
    rst = 1;
    #1 chk("midcount_reset", 4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    chk("midcount_held", 4'b0000, 4'b0000, 4'b0000);
    rst = 0;
    repeat (L-1) step();
    chk("midcount_early", 4'b0000, 4'b0000, 4'b0000);
    step();
    chk("midcount_rise", 4'b0010, 4'b0000, 4'b0000);
    sw = 4'b0000;
    repeat (L-1) step();
    chk("rel1_early", 4'b0010, 4'b0000, 4'b0000);
    step();
    chk("rel1_edge", 4'b0000, 4'b0010, 4'b0010);
    step();
    chk("rel1_after", 4'b0000, 4'b0000, 4'b0010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
